ctech_lib_latch_rf_rd: RTL and testbench
========================================

Name: ctech_lib_latch_rf_rd

Overview:
Read port for a latch-based register file whose storage cells are ctech latch instances written on the low clock phase.
- Takes the flattened latch array contents and accepts read requests on a valid/ready handshake.
- Returns registered read data through a 2-entry output queue.
- Sits between the latch array and its consumer, so consumers never sample transparent latch outputs directly.

Parameters:
DEPTH, 8, number of words in the latch array (2..64, need not be a power of 2)
WIDTH, 32, bits per word
AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
rd_vld  input  1  read request valid
rd_rdy  output  1  read request ready
rd_addr  input  AW  read word address
arr_q  input  DEPTH*WIDTH  latch array contents; word i at bits [i*WIDTH +: WIDTH]
wr_en  input  1  array write occurring this cycle (latches update after the capturing edge)
wr_addr  input  AW  array write address
wr_data  input  WIDTH  array write data
rsp_vld  output  1  response valid
rsp_rdy  input  1  response ready
rsp_data  output  WIDTH  read data
rsp_addr  output  AW  address of the returned word
rsp_err  output  1  address out of range (rd_addr >= DEPTH)

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values:
  - rsp_vld=0, rsp_data=0, rsp_addr=0, rsp_err=0.
  - Queue count cnt=0, read and write pointers=0.
  - rd_rdy=0 while rst is high.
- Accept and release:
  - rd_rdy = !rst && (cnt != 2). It is derived from registered state only, with no combinational path from rsp_rdy.
  - A request is accepted on a rising edge where rd_vld && rd_rdy.
  - A response is released on a rising edge where rsp_vld && rsp_rdy.
- Capture at accept:
  - Entry data = arr_q word rd_addr; entry addr = rd_addr.
  - Entry err = (rd_addr >= DEPTH). When err=1, entry data is forced to 0.
  - The data is a snapshot. Writes after the accept edge never modify queued entries.
- Latency: an accept at edge N with cnt=0 gives rsp_vld=1 after edge N, i.e. 1 cycle.
- Queue:
  - 2 entries, FIFO order. rsp_* always presents the head entry.
  - rsp_vld = (cnt != 0).
- Queue boundary cases:
  - Simultaneous accept and release: cnt unchanged, new entry queued behind the remaining one.
  - At cnt=2 no accept occurs (rd_rdy=0). A release that edge makes rd_rdy=1 the next cycle.
  - At cnt=0 with rsp_rdy=1 nothing is released. rsp_data holds its last value; consumers must qualify with rsp_vld.
  - Pointers are 1 bit each and wrap naturally.
- Handshake stability: while rsp_vld=1 and rsp_rdy=0, rsp_data, rsp_addr and rsp_err stay stable.
- Write collision (wr_en && wr_addr == rd_addr on the accept edge): behaviour is set by the optional feature below.
- Reset mid-operation:
  - All queued entries are discarded immediately (asynchronous).
  - Outputs return to reset values without waiting for a clock edge.
- Unknown/X on rd_addr while rd_vld=0 has no effect on state.

Optional Feature:
CTECH_LATCH_RF_RD_BYPASS_EN
- Defined: on a write collision the captured data is wr_data, i.e. read-after-same-cycle-write returns new data.
  - Out-of-range addresses are never bypassed.
- Undefined: the captured data is the arr_q word, i.e. old data.
  - wr_en, wr_addr and wr_data are unused but remain as ports, so the interface is identical in both builds.

Test Plan:
1. Reset then single read: arr_q word 3 = 0xDEADBEEF, rd_addr=3, rsp_rdy=1 -> rsp_vld=1 one cycle after accept, rsp_data=0xDEADBEEF, rsp_addr=3, rsp_err=0.
2. Backpressure: rsp_rdy=0, issue reads to addr 1, 2, 5 back to back -> first two accepted, rd_rdy=0 after the second, third held. Raise rsp_rdy -> responses come out in order 1, 2, 5 with data stable while stalled.
3. Snapshot: read addr 4 (value 0x11) with rsp_rdy=0, then change arr_q word 4 to 0x22 -> response still 0x11.
4. Collision: rd_addr=6, wr_en=1, wr_addr=6, wr_data=0xA5A5A5A5, arr_q word 6=0x0 -> with macro defined rsp_data=0xA5A5A5A5; without it rsp_data=0x0.
5. Out of range: DEPTH=6, rd_addr=7 -> rsp_err=1, rsp_data=0, rsp_addr=7.
6. Async reset mid-operation: cnt=2, assert rst between edges -> rsp_vld=0 and rd_rdy=0 immediately. After release, rd_rdy=1 and no stale responses appear.

Source files
------------

// File: rtl/ctech_lib_latch_rf_rd_if.sv
// ctech_lib_latch_rf_rd_if: request/response bundle between a latch register file read port and its consumer
// Ports (signals):
//   rd_vld/rd_rdy/rd_addr             read request handshake and word address
//   rsp_vld/rsp_rdy                   response handshake
//   rsp_data/rsp_addr/rsp_err         returned word, its address, out-of-range flag
// Modports: master = consumer side, slave = read port side.
interface ctech_lib_latch_rf_rd_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
);
    logic             rd_vld;
    logic             rd_rdy;
    logic [AW-1:0]    rd_addr;
    logic             rsp_vld;
    logic             rsp_rdy;
    logic [WIDTH-1:0] rsp_data;
    logic [AW-1:0]    rsp_addr;
    logic             rsp_err;
    modport master (
        output rd_vld, rd_addr, rsp_rdy,
        input  rd_rdy, rsp_vld, rsp_data, rsp_addr, rsp_err
    );
    modport slave (
        input  rd_vld, rd_addr, rsp_rdy,
        output rd_rdy, rsp_vld, rsp_data, rsp_addr, rsp_err
    );
endinterface

// File: rtl/ctech_lib_latch_rf_rd.sv
// ctech_lib_latch_rf_rd: registered read port with a 2-entry response queue for a latch-based register file
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   rf (slave modport)       rd_vld/rd_rdy/rd_addr request, rsp_vld/rsp_rdy/rsp_data/rsp_addr/rsp_err response
//   arr_q                    flattened latch contents, word i at [i*WIDTH +: WIDTH]
//   wr_en, wr_addr, wr_data  array write in progress this cycle
// Build option: define CTECH_LATCH_RF_RD_BYPASS_EN to return wr_data on a same-cycle write to the read address.
module ctech_lib_latch_rf_rd #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    ctech_lib_latch_rf_rd_if.slave rf,
    input  logic [DEPTH*WIDTH-1:0] arr_q,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data
);
    logic [WIDTH-1:0] q_data [2];
    logic [AW-1:0]    q_addr [2];
    logic             q_err  [2];
    logic             wp;
    logic             rp;
    logic [1:0]       cnt;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] cap_data;
    logic             hit;
    logic             acc;
    logic             rel;
    logic             hd;
    // Decode doubles as the range check: no matching word means out of range, data stays 0.
    always_comb begin
        rd_word = '0;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rf.rd_addr == AW'(i)) begin
                rd_word = arr_q[i*WIDTH +: WIDTH];
                hit = 1'b1;
            end
        end
    end
`ifdef CTECH_LATCH_RF_RD_BYPASS_EN
    assign cap_data = (hit && wr_en && wr_addr == rf.rd_addr) ? wr_data : rd_word;
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};
    assign cap_data = rd_word;
`endif
    assign rf.rd_rdy  = !rst && cnt != 2'd2;
    assign rf.rsp_vld = cnt != 2'd0;
    assign acc = rf.rd_vld && rf.rd_rdy;
    assign rel = rf.rsp_vld && rf.rsp_rdy;
    // When empty, the slot behind rp is the last released entry, so outputs hold their last value.
    assign hd = (cnt == 2'd0) ? ~rp : rp;
    assign rf.rsp_data = q_data[hd];
    assign rf.rsp_addr = q_addr[hd];
    assign rf.rsp_err  = q_err[hd];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_data <= '{default: '0};
            q_addr <= '{default: '0};
            q_err  <= '{default: 1'b0};
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (acc) begin
                q_data[wp] <= cap_data;
                q_addr[wp] <= rf.rd_addr;
                q_err[wp]  <= !hit;
                wp         <= ~wp;
            end
            if (rel) rp <= ~rp;
            cnt <= cnt + {1'b0, acc} - {1'b0, rel};
        end
    end
endmodule

// File: tb/tb_ctech_lib_latch_rf_rd.sv
// tb_ctech_lib_latch_rf_rd: scoreboard bench for the latch register file read port
module tb_ctech_lib_latch_rf_rd;
    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  a;
        logic        e;
    } ent_t;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  words [8];
    logic [255:0] arr_q;
    logic [191:0] arr_q6;
    logic         wr_en = 1'b0;
    logic [2:0]   wr_addr = '0;
    logic [31:0]  wr_data = '0;
    ent_t         sb [$];
    int           n_tests = 0;
    int           n_fail = 0;
    ctech_lib_latch_rf_rd_if #(.WIDTH(32), .AW(3)) m ();
    ctech_lib_latch_rf_rd_if #(.WIDTH(32), .AW(3)) o ();
    always #5 clk = ~clk;
    always_comb begin
        arr_q = '0;
        for (int i = 0; i < 8; i++) arr_q[i*32 +: 32] = words[i];
    end
    assign arr_q6 = arr_q[191:0];
    ctech_lib_latch_rf_rd #(.DEPTH(8), .WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .rf(m.slave), .arr_q(arr_q),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );
    ctech_lib_latch_rf_rd #(.DEPTH(6), .WIDTH(32)) u_oor (
        .clk(clk), .rst(rst), .rf(o.slave), .arr_q(arr_q6),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic ent_t model(input logic [2:0] a);
        ent_t e;
        e.a = a;
        e.e = 1'b0;
        e.d = words[a];
`ifdef CTECH_LATCH_RF_RD_BYPASS_EN
        if (wr_en && wr_addr == a) e.d = wr_data;
`endif
        return e;
    endfunction
    // Handshakes are sampled on the falling edge; the rising edge then commits them.
    task automatic step();
        ent_t e;
        @(negedge clk);
        if (m.rsp_vld && m.rsp_rdy) begin
            if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("sb_data", 64'(m.rsp_data), 64'(e.d));
                chk("sb_addr", 64'(m.rsp_addr), 64'(e.a));
                chk("sb_err", 64'(m.rsp_err), 64'(e.e));
            end
        end
        if (m.rd_vld && m.rd_rdy) sb.push_back(model(m.rd_addr));
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [31:0] held;
        logic [2:0] oa [3];
        for (int i = 0; i < 8; i++) words[i] = 32'h0101_0101 * 32'(i + 1);
        m.rd_vld = 1'b0; m.rd_addr = '0; m.rsp_rdy = 1'b0;
        o.rd_vld = 1'b0; o.rd_addr = '0; o.rsp_rdy = 1'b0;
        repeat (3) step();
        chk("rst_rsp_vld", 64'(m.rsp_vld), 64'd0);
        chk("rst_rd_rdy", 64'(m.rd_rdy), 64'd0);
        chk("rst_rsp_data", 64'(m.rsp_data), 64'd0);
        chk("rst_rsp_addr", 64'(m.rsp_addr), 64'd0);
        chk("rst_rsp_err", 64'(m.rsp_err), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_rd_rdy", 64'(m.rd_rdy), 64'd1);
        // single read, one-cycle latency
        words[3] = 32'hDEAD_BEEF;
        m.rd_vld = 1'b1; m.rd_addr = 3'd3; m.rsp_rdy = 1'b1;
        step();
        m.rd_vld = 1'b0;
        chk("t1_vld", 64'(m.rsp_vld), 64'd1);
        chk("t1_data", 64'(m.rsp_data), 64'hDEAD_BEEF);
        chk("t1_addr", 64'(m.rsp_addr), 64'd3);
        chk("t1_err", 64'(m.rsp_err), 64'd0);
        step();
        chk("t1_empty", 64'(m.rsp_vld), 64'd0);
        chk("t1_hold", 64'(m.rsp_data), 64'hDEAD_BEEF);
        // backpressure and ordering
        m.rsp_rdy = 1'b0;
        m.rd_vld = 1'b1; m.rd_addr = 3'd1; step();
        m.rd_addr = 3'd2; step();
        chk("t2_full_rdy", 64'(m.rd_rdy), 64'd0);
        m.rd_addr = 3'd5; step();
        held = m.rsp_data;
        step();
        chk("t2_stall_data", 64'(m.rsp_data), 64'(held));
        chk("t2_stall_val", 64'(m.rsp_data), 64'(words[1]));
        chk("t2_stall_addr", 64'(m.rsp_addr), 64'd1);
        chk("t2_still_full", 64'(m.rd_rdy), 64'd0);
        m.rsp_rdy = 1'b1;
        step();
        chk("t2_rdy_back", 64'(m.rd_rdy), 64'd1);
        chk("t2_head2", 64'(m.rsp_addr), 64'd2);
        step();
        chk("t2_head5", 64'(m.rsp_addr), 64'd5);
        chk("t2_simul_vld", 64'(m.rsp_vld), 64'd1);
        m.rd_vld = 1'b0;
        step();
        chk("t2_drained", 64'(m.rsp_vld), 64'd0);
        // snapshot
        words[4] = 32'h11;
        m.rsp_rdy = 1'b0; m.rd_vld = 1'b1; m.rd_addr = 3'd4;
        step();
        m.rd_vld = 1'b0;
        words[4] = 32'h22;
        step(); step();
        chk("t3_snapshot", 64'(m.rsp_data), 64'h11);
        m.rsp_rdy = 1'b1;
        step();
        // write collision
        words[6] = 32'h0;
        m.rsp_rdy = 1'b0; m.rd_vld = 1'b1; m.rd_addr = 3'd6;
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'hA5A5_A5A5;
        step();
        m.rd_vld = 1'b0; wr_en = 1'b0;
        words[6] = 32'hA5A5_A5A5;
`ifdef CTECH_LATCH_RF_RD_BYPASS_EN
        chk("t4_collision", 64'(m.rsp_data), 64'hA5A5_A5A5);
`else
        chk("t4_collision", 64'(m.rsp_data), 64'h0);
`endif
        m.rsp_rdy = 1'b1;
        step();
        // range boundary on the DEPTH=6 instance
        oa[0] = 3'd5; oa[1] = 3'd6; oa[2] = 3'd7;
        o.rsp_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            o.rd_vld = 1'b1; o.rd_addr = oa[k];
            step();
            o.rd_vld = 1'b0;
            chk("t5_vld", 64'(o.rsp_vld), 64'd1);
            chk("t5_err", 64'(o.rsp_err), (oa[k] >= 3'd6) ? 64'd1 : 64'd0);
            chk("t5_data", 64'(o.rsp_data), (oa[k] >= 3'd6) ? 64'd0 : 64'(words[oa[k]]));
            chk("t5_addr", 64'(o.rsp_addr), 64'(oa[k]));
            step();
        end
        // asynchronous reset with a full queue
        m.rsp_rdy = 1'b0; m.rd_vld = 1'b1; m.rd_addr = 3'd0; step();
        m.rd_addr = 3'd7; step();
        m.rd_vld = 1'b0;
        chk("t6_full", 64'(m.rd_rdy), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        chk("t6_rst_vld", 64'(m.rsp_vld), 64'd0);
        chk("t6_rst_rdy", 64'(m.rd_rdy), 64'd0);
        chk("t6_rst_data", 64'(m.rsp_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_rdy_after", 64'(m.rd_rdy), 64'd1);
        m.rsp_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_no_stale", 64'(m.rsp_vld), 64'd0);
        end
        // random traffic with latch writes landing after the capturing edge
        for (int c = 0; c < 300; c++) begin
            m.rd_vld = 1'($urandom_range(0, 1));
            m.rd_addr = 3'($urandom);
            m.rsp_rdy = 1'($urandom_range(0, 1));
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = 3'($urandom);
            wr_data = $urandom;
            step();
            if (wr_en) words[wr_addr] = wr_data;
        end
        m.rd_vld = 1'b0; wr_en = 1'b0; m.rsp_rdy = 1'b1;
        for (int k = 0; k < 10 && sb.size() != 0; k++) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("end_vld", 64'(m.rsp_vld), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
